// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and types for the IO port device
package io_pkg;
    localparam int DATA_WIDTH_DEFAULT = 16;
    typedef logic [DATA_WIDTH_DEFAULT-1:0] io_word_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
// Callers qualify wr_en/rd_en; a write while full is legal only alongside a read.
module sync_fifo
    import io_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
endmodule

// File: rtl/io_port_device.sv
// rtl/io_port_device.sv - processor-facing IO peripheral with input and output FIFOs
module io_port_device
    import io_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int IN_DEPTH   = 8,
    parameter int OUT_DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ioe,
    input  logic                         ior,
    input  logic                         iow,
    input  logic [DATA_WIDTH-1:0]        port_out,
    output logic [DATA_WIDTH-1:0]        port_in,
    input  logic                         in_wr_valid,
    input  logic [DATA_WIDTH-1:0]        in_wr_data,
    output logic                         in_wr_ready,
    output logic                         out_rd_valid,
    output logic [DATA_WIDTH-1:0]        out_rd_data,
    input  logic                         out_rd_ready,
    output logic [$clog2(IN_DEPTH):0]    in_count,
    output logic [$clog2(OUT_DEPTH):0]   out_count,
    output logic                         in_underrun,
    output logic                         out_overflow
);
    logic                  rd_stb;
    logic                  wr_stb;
    logic                  write_pending;
    logic                  in_full;
    logic                  in_empty;
    logic                  in_push;
    logic                  in_pop;
    logic [DATA_WIDTH-1:0] in_head;
    logic                  out_full;
    logic                  out_empty;
    logic                  out_push;
    logic                  out_pop;

    assign rd_stb = ioe & ior;
    assign wr_stb = ioe & iow;

    assign in_wr_ready = ~in_full;
    assign in_push     = in_wr_valid & ~in_full;
    assign in_pop      = rd_stb & ~in_empty;

    // A capture into a full output FIFO still fits when the host pops that cycle.
    assign out_rd_valid = ~out_empty;
    assign out_pop      = out_rd_ready & ~out_empty;
    assign out_push     = write_pending & (~out_full | out_pop);

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_push),
        .wr_data (in_wr_data),
        .rd_en   (in_pop),
        .rd_data (in_head),
        .count   (in_count),
        .full    (in_full),
        .empty   (in_empty)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (out_push),
        .wr_data (port_out),
        .rd_en   (out_pop),
        .rd_data (out_rd_data),
        .count   (out_count),
        .full    (out_full),
        .empty   (out_empty)
    );

    // port_out is registered in the processor, so the capture lags the strobe by one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_in       <= '0;
            write_pending <= 1'b0;
            in_underrun   <= 1'b0;
            out_overflow  <= 1'b0;
        end else begin
            if (!in_empty) port_in <= in_head;
            write_pending <= wr_stb;
            if (rd_stb && in_empty) in_underrun <= 1'b1;
            if (write_pending && out_full && !out_pop) out_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_io_port_device.sv
// tb/tb_io_port_device.sv - self-checking bench for io_port_device
module tb_io_port_device;
    localparam int DW = 16;
    localparam int ID = 8;
    localparam int OD = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ioe, ior, iow;
    logic [DW-1:0] port_out;
    logic [DW-1:0] port_in;
    logic          in_wr_valid;
    logic [DW-1:0] in_wr_data;
    logic          in_wr_ready;
    logic          out_rd_valid;
    logic [DW-1:0] out_rd_data;
    logic          out_rd_ready;
    logic [3:0]    in_count;
    logic [3:0]    out_count;
    logic          in_underrun;
    logic          out_overflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] in_q[$];
    logic [DW-1:0] out_q[$];
    logic [DW-1:0] m_port_in;
    bit            m_pend, m_under, m_over;

    always #5 clk = ~clk;

    io_port_device #(.DATA_WIDTH(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
        .clk          (clk),
        .reset        (reset),
        .ioe          (ioe),
        .ior          (ior),
        .iow          (iow),
        .port_out     (port_out),
        .port_in      (port_in),
        .in_wr_valid  (in_wr_valid),
        .in_wr_data   (in_wr_data),
        .in_wr_ready  (in_wr_ready),
        .out_rd_valid (out_rd_valid),
        .out_rd_data  (out_rd_data),
        .out_rd_ready (out_rd_ready),
        .in_count     (in_count),
        .out_count    (out_count),
        .in_underrun  (in_underrun),
        .out_overflow (out_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        m_port_in = '0;
        m_pend    = 1'b0;
        m_under   = 1'b0;
        m_over    = 1'b0;
    endtask

    // One clock edge of the device, expressed as queue operations.
    task automatic model_edge();
        int n_in, n_out;
        bit rd, wr, pop_out;
        logic [DW-1:0] nxt;
        rd    = ioe & ior;
        wr    = ioe & iow;
        n_in  = in_q.size();
        n_out = out_q.size();
        nxt   = (n_in > 0) ? in_q[0] : m_port_in;
        if (rd) begin
            if (n_in > 0) void'(in_q.pop_front());
            else m_under = 1'b1;
        end
        if (in_wr_valid && n_in < ID) in_q.push_back(in_wr_data);
        pop_out = out_rd_ready && (n_out > 0);
        if (pop_out) void'(out_q.pop_front());
        if (m_pend) begin
            if (n_out < OD || pop_out) out_q.push_back(port_out);
            else m_over = 1'b1;
        end
        m_pend    = wr;
        m_port_in = nxt;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".port_in"}, 32'(port_in), 32'(m_port_in));
        chk({tag, ".in_count"}, 32'(in_count), 32'(in_q.size()));
        chk({tag, ".out_count"}, 32'(out_count), 32'(out_q.size()));
        chk({tag, ".in_wr_ready"}, 32'(in_wr_ready), 32'(in_q.size() < ID));
        chk({tag, ".out_rd_valid"}, 32'(out_rd_valid), 32'(out_q.size() > 0));
        if (out_q.size() > 0) chk({tag, ".out_rd_data"}, 32'(out_rd_data), 32'(out_q[0]));
        chk({tag, ".in_underrun"}, 32'(in_underrun), 32'(m_under));
        chk({tag, ".out_overflow"}, 32'(out_overflow), 32'(m_over));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        ioe = 0; ior = 0; iow = 0;
        in_wr_valid = 0; out_rd_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        port_out   = '0;
        in_wr_data = '0;
        do_reset();

        // Two pushes, then the first word reaches port_in.
        in_wr_valid = 1; in_wr_data = 16'hAAAA; step("push0");
        in_wr_data = 16'hBBBB;                  step("push1");
        in_wr_valid = 0;                        step("push_idle");
        chk("push.port_in", 32'(port_in), 32'h0000AAAA);
        chk("push.in_count", 32'(in_count), 32'd2);

        // Read handshakes.
        ioe = 1; ior = 1; step("rd0");
        idle();           step("rd0_idle");
        chk("rd0.port_in", 32'(port_in), 32'h0000BBBB);
        chk("rd0.in_count", 32'(in_count), 32'd1);
        ioe = 1; ior = 1; step("rd1");
        idle();           step("rd1_idle");
        chk("rd1.port_in", 32'(port_in), 32'h0000BBBB);
        chk("rd1.in_count", 32'(in_count), 32'd0);

        // Masked read, then real underrun.
        ior = 1; step("masked_rd");
        chk("masked.in_underrun", 32'(in_underrun), 32'd0);
        ioe = 1; step("underrun");
        chk("underrun.flag", 32'(in_underrun), 32'd1);
        chk("underrun.port_in", 32'(port_in), 32'h0000BBBB);
        idle();

        // Two back-to-back writes, capture lags by one edge.
        ioe = 1; iow = 1; port_out = 16'h0000; step("wr0");
        port_out = 16'h5555;                   step("wr1");
        idle(); port_out = 16'h6666;           step("wr_cap");
        port_out = 16'h0000;                   step("wr_idle");
        chk("wr.out_rd_data", 32'(out_rd_data), 32'h00005555);
        chk("wr.out_count", 32'(out_count), 32'd2);
        out_rd_ready = 1; step("pop0");
        chk("pop0.out_rd_data", 32'(out_rd_data), 32'h00006666);
        step("pop1");
        chk("pop1.out_rd_valid", 32'(out_rd_valid), 32'd0);
        idle();

        // Nine writes into an eight-deep output FIFO without draining.
        for (int k = 0; k < 10; k++) begin
            ioe = 1; iow = (k < 9);
            port_out = (k > 0) ? 16'(16'h7777 + k - 1) : 16'h0000;
            step("ovf_wr");
        end
        idle(); step("ovf_idle");
        chk("ovf.out_count", 32'(out_count), 32'd8);
        chk("ovf.flag", 32'(out_overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("ovf.drain", 32'(out_rd_data), 32'(16'h7777 + i));
            out_rd_ready = 1; step("ovf_pop");
        end
        out_rd_ready = 0;
        chk("ovf.ninth_absent", 32'(out_rd_valid), 32'd0);

        // Same again, with a host pop on the ninth capture.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            ioe = 1; iow = (k < 9);
            port_out = (k > 0) ? 16'(16'h7777 + k - 1) : 16'h0000;
            out_rd_ready = (k == 9);
            step("full_pop_wr");
        end
        idle(); step("full_pop_idle");
        chk("full_pop.out_count", 32'(out_count), 32'd8);
        chk("full_pop.flag", 32'(out_overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("full_pop.drain", 32'(out_rd_data), 32'(16'h7778 + i));
            out_rd_ready = 1; step("full_pop_pop");
        end
        idle();

        // Asynchronous reset with data queued on both sides.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ioe = 1; ior = (k == 0); iow = (k < 2);
            in_wr_valid = (k < 3); in_wr_data = 16'($urandom);
            port_out = 16'($urandom);
            step("mid_fill");
        end
        idle(); step("mid_idle");
        chk("mid.in_count", 32'(in_count), 32'd3);
        chk("mid.out_count", 32'(out_count), 32'd2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async.in_count", 32'(in_count), 32'd0);
        chk("async.out_count", 32'(out_count), 32'd0);
        chk("async.port_in", 32'(port_in), 32'd0);
        chk("async.in_underrun", 32'(in_underrun), 32'd0);
        chk("async.out_overflow", 32'(out_overflow), 32'd0);
        chk("async.out_rd_valid", 32'(out_rd_valid), 32'd0);
        chk("async.in_wr_ready", 32'(in_wr_ready), 32'd1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the queue model, with shifting fill/drain bias.
        for (int n = 0; n < 600; n++) begin
            int bias;
            bias = (n / 100) % 3;
            ioe          = ($urandom_range(0, 3) != 0);
            ior          = ($urandom_range(0, 3) < (bias == 0 ? 1 : 2));
            iow          = ($urandom_range(0, 3) < (bias == 1 ? 1 : 2));
            port_out     = 16'($urandom);
            in_wr_valid  = ($urandom_range(0, 3) < (bias == 2 ? 1 : 3));
            in_wr_data   = 16'($urandom);
            out_rd_ready = ($urandom_range(0, 3) < (bias == 1 ? 3 : 1));
            step("rand");
        end
        idle();
        step("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
